// File: rtl/pipe_wb_regfile.sv
// pipe_wb_regfile: write-back stage and 8x64 register file (1 write, 2 read) with a pending-write scoreboard.
// Defining WRITE_BYPASS_EN adds write-first forwarding from the write port onto both read ports.
module pipe_wb_regfile #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 3,
   parameter int NREG   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              WRegEn_in,
   input  logic [ADDR_W-1:0] WReg1_in,
   input  logic [DATA_W-1:0] Wdata_in,
   input  logic [ADDR_W-1:0] RAddr1,
   input  logic [ADDR_W-1:0] RAddr2,
   output logic [DATA_W-1:0] RData1,
   output logic [DATA_W-1:0] RData2,
   input  logic              sb_set_en,
   input  logic [ADDR_W-1:0] sb_set_addr,
   output logic [NREG-1:0]   busy,
   output logic              hazard1,
   output logic              hazard2
);

   logic [DATA_W-1:0] r_regs [NREG];
   logic [NREG-1:0]   r_busy;

   logic              w_commit;
   logic [NREG-1:0]   w_set;
   logic [NREG-1:0]   w_clr;
   logic              w_byp1;
   logic              w_byp2;

   assign w_commit = en & WRegEn_in;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      w_set[sb_set_addr] = sb_set_en;
      w_clr[WReg1_in]    = w_commit;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_commit) begin
         r_regs[WReg1_in] <= Wdata_in;
      end
   end

   // Clear is applied before set so a new producer issued in the commit cycle keeps its bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_busy <= '0;
      end else if (en) begin
         r_busy <= (r_busy & ~w_clr) | w_set;
      end
   end

`ifdef WRITE_BYPASS_EN
   assign w_byp1 = w_commit & (WReg1_in == RAddr1);
   assign w_byp2 = w_commit & (WReg1_in == RAddr2);
`else
   assign w_byp1 = 1'b0;
   assign w_byp2 = 1'b0;
`endif

   assign RData1  = w_byp1 ? Wdata_in : r_regs[RAddr1];
   assign RData2  = w_byp2 ? Wdata_in : r_regs[RAddr2];
   assign busy    = r_busy;
   assign hazard1 = r_busy[RAddr1] & ~w_byp1;
   assign hazard2 = r_busy[RAddr2] & ~w_byp2;

endmodule
